// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// pc_fetch : MIPS fetch stage. Holds the PC, reads instruction memory and hands
//            {instr, pc, exception} to decode over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  instr_exc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_offset;
    logic [1:0]  pc_exc;

    // Offset compare covers the top of the range without a 33-bit add, so
    // addresses near 32'hFFFF_FFFC never wrap back into the legal window.
    always_comb begin
        pc_offset = pc - IMEM_BASE;
        pc_exc    = EXC_NONE;
        if (pc[1:0] != 2'b00)
            pc_exc = EXC_ALIGN;
        else if ((pc < IMEM_BASE) || (pc_offset >= IMEM_SIZE))
            pc_exc = EXC_RANGE;
    end

    assign imem_req  = reset && (state == ST_REQ) && (pc_exc == EXC_NONE);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_exc   <= EXC_NONE;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (pc_exc != EXC_NONE) begin
                        instr       <= 32'h0;
                        instr_pc    <= pc;
                        instr_exc   <= pc_exc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (imem_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_exc   <= EXC_NONE;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        fetch_count <= fetch_count + 32'd1;
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire
